// File: rtl/multi_blinky_pkg.sv
// Shared types for the multi-channel LED blinker.
// Optional feature macro: MULTI_BLINKY_SYNC_EN (adds a phase-align input).
package multi_blinky_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e            mode;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] duty;
    } chan_cfg_t;

    // Index width for n items, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_blinky_channel.sv
// One LED channel: mode/period/duty registers, tick counter, LED level.
// Priority inside the channel: rst > sync_i > load_i > tick_i.
// Optional feature macro: MULTI_BLINKY_SYNC_EN (adds sync_i).
module blinky_channel
    import multi_blinky_pkg::*;
#(
    parameter int               CNT_W          = 8,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = 99
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MULTI_BLINKY_SYNC_EN
    input  logic             sync_i,
`endif
    input  logic             tick_i,
    input  logic             load_i,
    input  mode_e            cfg_mode_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [CNT_W-1:0] cfg_duty_i,
    output logic             led_o,
    output logic [CNT_W-1:0] cnt_o
);

    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             led_q, led_d;

    // Next-state: alignment, then config load, then tick-driven update.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        cnt_d    = cnt_q;
        led_d    = led_q;
        cnt_inc  = (cnt_q == period_q) ? '0 : cnt_q + 1'b1;
`ifdef MULTI_BLINKY_SYNC_EN
        if (sync_i) begin
            cnt_d = '0;
            if (mode_q == MODE_BLINK || mode_q == MODE_PWM) begin
                led_d = 1'b0;
            end
        end else
`endif
        if (load_i) begin
            mode_d   = cfg_mode_i;
            period_d = cfg_period_i;
            duty_d   = cfg_duty_i;
            cnt_d    = '0;
            led_d    = (cfg_mode_i == MODE_ON);
        end else if (tick_i) begin
            cnt_d = cnt_inc;
            case (mode_q)
                MODE_OFF:   led_d = 1'b0;
                MODE_ON:    led_d = 1'b1;
                MODE_BLINK: led_d = led_q ^ (cnt_q == period_q);
                MODE_PWM:   led_d = (cnt_inc < duty_q);
                default:    led_d = 1'b0;
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            period_q <= DEFAULT_PERIOD;
            duty_q   <= '0;
            cnt_q    <= '0;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
        end
    end

    assign led_o = led_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/multi_blinky.sv
// Multi-channel LED blinker: shared prescaler, config write port, one
// blinky_channel per LED. LED outputs are registered, active-high.
// Config handshake: a write is accepted on any edge where cfg_valid_i and
// cfg_ready_o are both high; cfg_ready_o is low in reset and high otherwise.
// Optional feature macro: MULTI_BLINKY_SYNC_EN (sync_i phase-aligns all
// channels and the prescaler; priority rst > sync_i > write > tick).
module multi_blinky
    import multi_blinky_pkg::*;
#(
    parameter int               NUM_LEDS       = 5,
    parameter int               TICK_DIV       = 16000,
    parameter int               CNT_W          = 8,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = 8'd99,
    localparam int              CHAN_W         = idx_width(NUM_LEDS),
    localparam int              PRE_W          = idx_width(TICK_DIV)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef MULTI_BLINKY_SYNC_EN
    input  logic                sync_i,
`endif
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CHAN_W-1:0]   cfg_chan_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [CNT_W-1:0]    cfg_period_i,
    input  logic [CNT_W-1:0]    cfg_duty_i,
    output logic                cfg_err_o,
    output logic                tick_o,
    output logic [NUM_LEDS-1:0] led_o
);

`ifdef MULTI_BLINKY_SYNC_EN
    logic sync_w;
    assign sync_w = sync_i;
`else
    localparam logic sync_w = 1'b0;
`endif

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic                ready_q;
    logic                err_q, err_d;
    logic                tick;
    logic                accept;
    logic                chan_ok;
    logic [NUM_LEDS-1:0] load;
    logic [NUM_LEDS-1:0] led_w;
    logic [CNT_W-1:0]    cnt_w [NUM_LEDS];

    assign tick    = !rst && (pre_cnt_q == PRE_W'(TICK_DIV - 1));
    assign accept  = cfg_valid_i && ready_q;
    assign chan_ok = 32'(cfg_chan_i) < NUM_LEDS;

    // Prescaler wrap/clear and invalid-channel error pulse.
    always_comb begin
        pre_cnt_d = (pre_cnt_q == PRE_W'(TICK_DIV - 1)) ? '0 : pre_cnt_q + 1'b1;
        if (sync_w) begin
            pre_cnt_d = '0;
        end
        err_d = accept && !chan_ok && !sync_w;
    end

    // Prescaler, ready and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            ready_q   <= 1'b1;
            err_q     <= err_d;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        assign load[i] = accept && chan_ok && !sync_w && (cfg_chan_i == CHAN_W'(i));

        blinky_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
`ifdef MULTI_BLINKY_SYNC_EN
            .sync_i       (sync_w),
`endif
            .tick_i       (tick),
            .load_i       (load[i]),
            .cfg_mode_i   (mode_e'(cfg_mode_i)),
            .cfg_period_i (cfg_period_i),
            .cfg_duty_i   (cfg_duty_i),
            .led_o        (led_w[i]),
            .cnt_o        (cnt_w[i])
        );
    end

    assign cfg_ready_o = ready_q;
    assign cfg_err_o   = err_q;
    assign tick_o      = tick;
    assign led_o       = led_w;

endmodule

// File: tb/tb_multi_blinky.sv
// Bench for multi_blinky. Five channels are used so that a 3-bit channel
// address has unused values (5..7) to exercise the invalid-channel path.
// The reference model tracks, per channel, the number of ticks seen since
// the last load and derives the LED level from that count arithmetically.
module tb_multi_blinky;
    import multi_blinky_pkg::*;

    localparam int NL = 5;
    localparam int TD = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid_i = 1'b0;
    logic [CW-1:0] cfg_chan_i = '0;
    logic [1:0]    cfg_mode_i = '0;
    logic [7:0]    cfg_period_i = '0;
    logic [7:0]    cfg_duty_i = '0;
    logic          cfg_ready_o;
    logic          cfg_err_o;
    logic          tick_o;
    logic [NL-1:0] led_o;
`ifdef MULTI_BLINKY_SYNC_EN
    logic          sync_i = 1'b0;
`endif

    multi_blinky #(
        .NUM_LEDS       (NL),
        .TICK_DIV       (TD),
        .CNT_W          (8),
        .DEFAULT_PERIOD (8'd99)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
`ifdef MULTI_BLINKY_SYNC_EN
        .sync_i       (sync_i),
`endif
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_chan_i   (cfg_chan_i),
        .cfg_mode_i   (cfg_mode_i),
        .cfg_period_i (cfg_period_i),
        .cfg_duty_i   (cfg_duty_i),
        .cfg_err_o    (cfg_err_o),
        .tick_o       (tick_o),
        .led_o        (led_o)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit tick_seen;

    // Reference model state
    int unsigned m_cyc;
    int unsigned m_n [NL];
    chan_cfg_t   m_cfg [NL];
    bit          m_err;
    bit          m_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_led(input int i);
        int unsigned len;
        len = int'(m_cfg[i].period) + 1;
        case (m_cfg[i].mode)
            MODE_ON:    return 1'b1;
            MODE_BLINK: return ((m_n[i] / len) % 2) == 1;
            MODE_PWM:   return (m_n[i] > 0) && ((m_n[i] % len) < int'(m_cfg[i].duty));
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [NL-1:0] exp_leds();
        logic [NL-1:0] v;
        for (int i = 0; i < NL; i++) v[i] = exp_led(i);
        return v;
    endfunction

    // Advance the model across one clock edge using the inputs of that cycle.
    task automatic model_edge(input bit r, input bit v, input logic [2:0] ch, input logic [1:0] md,
                              input logic [7:0] per, input logic [7:0] dt, input bit sy);
        bit tk;
        bit acc;
        if (r) begin
            m_cyc = 0; m_err = 0; m_ready = 0;
            for (int i = 0; i < NL; i++) begin
                m_n[i] = 0;
                m_cfg[i] = '{MODE_OFF, 8'd99, 8'd0};
            end
        end else begin
            tk  = (m_cyc % TD) == TD - 1;
            acc = v && m_ready;
            if (sy) begin
                m_cyc = 0; m_err = 0;
                for (int i = 0; i < NL; i++) m_n[i] = 0;
            end else begin
                m_cyc++;
                m_err = acc && (int'(ch) >= NL);
                for (int i = 0; i < NL; i++) begin
                    if (acc && int'(ch) == i) begin
                        m_cfg[i] = '{mode_e'(md), per, dt};
                        m_n[i] = 0;
                    end else if (tk) begin
                        m_n[i]++;
                    end
                end
            end
            m_ready = 1;
        end
    endtask

    // Driver: one clock cycle with the given inputs, then compare with model.
    task automatic step(input bit r, input bit v, input logic [2:0] ch, input logic [1:0] md,
                        input logic [7:0] per, input logic [7:0] dt, input bit sy);
        rst = r; cfg_valid_i = v; cfg_chan_i = ch; cfg_mode_i = md;
        cfg_period_i = per; cfg_duty_i = dt;
`ifdef MULTI_BLINKY_SYNC_EN
        sync_i = sy;
`endif
        #1;
        tick_seen = tick_o;
        @(posedge clk);
        model_edge(r, v, ch, md, per, dt, sy);
        #1;
        chk("led", 32'(led_o), 32'(exp_leds()));
        chk("tick", 32'(tick_o), 32'(!r && ((m_cyc % TD) == TD - 1)));
        chk("err", 32'(cfg_err_o), 32'(m_err));
        chk("ready", 32'(cfg_ready_o), 32'(m_ready));
    endtask

    task automatic idle(input int k);
        for (int s = 0; s < k; s++) step(0, 0, 3'd0, 2'd0, 8'd0, 8'd0, 0);
    endtask

    task automatic wr(input logic [2:0] ch, input mode_e md, input logic [7:0] per, input logic [7:0] dt);
        step(0, 1, ch, md, per, dt, 0);
    endtask

    task automatic count_high(input int ch, input int k, output int n);
        n = 0;
        for (int s = 0; s < k; s++) begin
            idle(1);
            n += int'(led_o[ch]);
        end
    endtask

    // After a BLINK load the first toggle must come on the third tick.
    task automatic blink_first_toggle(input int ch, input string tag);
        int ticks = 0;
        bit done = 0;
        for (int s = 0; s < 40 && !done; s++) begin
            idle(1);
            if (tick_seen) begin
                ticks++;
                if (ticks == 2) chk({tag, "_before_third_tick"}, 32'(led_o[ch]), 32'd0);
                if (ticks == 3) begin
                    chk({tag, "_third_tick"}, 32'(led_o[ch]), 32'd1);
                    done = 1;
                end
            end
        end
        chk({tag, "_tick_budget"}, 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [2:0]    chan;
        mode_e         mode;
        logic [NL-1:0] exp_led;
        bit            exp_err;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n;
        bit found;
        logic prev1;
        bit r_r, v_r, sy_r;

        tbl[0] = '{3'd2, MODE_ON,    5'b00100, 1'b0};
        tbl[1] = '{3'd2, MODE_OFF,   5'b00000, 1'b0};
        tbl[2] = '{3'd0, MODE_ON,    5'b00001, 1'b0};
        tbl[3] = '{3'd4, MODE_ON,    5'b10001, 1'b0};
        tbl[4] = '{3'd5, MODE_ON,    5'b10001, 1'b1};
        tbl[5] = '{3'd7, MODE_BLINK, 5'b10001, 1'b1};
        tbl[6] = '{3'd3, MODE_ON,    5'b11001, 1'b0};
        tbl[7] = '{3'd0, MODE_OFF,   5'b11000, 1'b0};
        tbl[8] = '{3'd6, MODE_ON,    5'b11000, 1'b1};
        tbl[9] = '{3'd4, MODE_OFF,   5'b01000, 1'b0};

        // Reset held three cycles
        for (int s = 0; s < 3; s++) step(1, 0, 3'd0, 2'd0, 8'd0, 8'd0, 0);
        chk("rst_led", 32'(led_o), 32'd0);
        chk("rst_ready", 32'(cfg_ready_o), 32'd0);
        chk("rst_err", 32'(cfg_err_o), 32'd0);
        chk("rst_tick", 32'(tick_o), 32'd0);
        idle(1);
        chk("ready_after_rst", 32'(cfg_ready_o), 32'd1);
        n = 0;
        for (int s = 0; s < 8; s++) begin
            idle(1);
            n += int'(tick_seen);
        end
        chk("tick_every_4th", 32'(n), 32'd2);

        // Table: ON/OFF writes and invalid channels
        foreach (tbl[i]) begin
            wr(tbl[i].chan, tbl[i].mode, 8'd5, 8'd0);
            chk("tbl_led", 32'(led_o), 32'(tbl[i].exp_led));
            chk("tbl_err", 32'(cfg_err_o), 32'(tbl[i].exp_err));
            idle(1);
            chk("tbl_err_one_cycle", 32'(cfg_err_o), 32'd0);
        end

        // BLINK period 2
        wr(3'd0, MODE_BLINK, 8'd2, 8'd0);
        blink_first_toggle(0, "blink");
        idle(30);

        // PWM period 3: duty 1, then 0, then above period
        wr(3'd1, MODE_PWM, 8'd3, 8'd1);
        idle(4);
        count_high(1, 48, n);
        chk("pwm_duty1_high_cycles", 32'(n), 32'd12);
        wr(3'd1, MODE_PWM, 8'd3, 8'd0);
        count_high(1, 40, n);
        chk("pwm_duty0_high_cycles", 32'(n), 32'd0);
        wr(3'd1, MODE_PWM, 8'd3, 8'd5);
        idle(4);
        count_high(1, 40, n);
        chk("pwm_duty5_high_cycles", 32'(n), 32'd40);

        // Write to ch0 in a tick cycle: ch0 restarts, ch1 still ticks
        wr(3'd1, MODE_BLINK, 8'd0, 8'd0);
        idle(2);
        found = 0;
        for (int s = 0; s < 8 && !found; s++) begin
            if (tick_o) found = 1;
            else idle(1);
        end
        chk("collision_tick_wait", 32'(found), 32'd1);
        prev1 = led_o[1];
        wr(3'd0, MODE_BLINK, 8'd2, 8'd0);
        chk("collision_ch1_toggled", 32'(led_o[1]), 32'(!prev1));
        chk("collision_ch0_cleared", 32'(led_o[0]), 32'd0);
        blink_first_toggle(0, "collision");

        // Reset mid-BLINK
        idle(5);
        step(1, 0, 3'd0, 2'd0, 8'd0, 8'd0, 0);
        chk("midrst_led", 32'(led_o), 32'd0);
        chk("midrst_ready", 32'(cfg_ready_o), 32'd0);
        step(1, 1, 3'd2, 2'd1, 8'd0, 8'd0, 0);
        chk("midrst_write_dropped", 32'(led_o), 32'd0);
        idle(6);

`ifdef MULTI_BLINKY_SYNC_EN
        // Channels at different phases, then align
        wr(3'd0, MODE_BLINK, 8'd2, 8'd0);
        idle(3);
        wr(3'd2, MODE_BLINK, 8'd2, 8'd0);
        idle(5);
        wr(3'd3, MODE_BLINK, 8'd2, 8'd0);
        idle(2);
        step(0, 0, 3'd0, 2'd0, 8'd0, 8'd0, 1);
        n = 0;
        for (int s = 0; s < 40; s++) begin
            idle(1);
            if (led_o[0] != led_o[2] || led_o[0] != led_o[3]) n++;
        end
        chk("sync_aligned_cycles", 32'(n), 32'd0);
`endif

        // Random stimulus against the model
        for (int s = 0; s < 600; s++) begin
            r_r  = ($urandom_range(0, 199) == 0);
            v_r  = ($urandom_range(0, 3) == 0);
            sy_r = 0;
`ifdef MULTI_BLINKY_SYNC_EN
            sy_r = ($urandom_range(0, 49) == 0);
`endif
            step(r_r, v_r, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 5)), 8'($urandom_range(0, 7)), sy_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
